// File: rtl/ram_port1_rr_arbiter.sv
// Round-robin arbiter sharing RAM read port 1 among NUM_REQ requesters.
// A tag pipeline follows each read through the RAM latency and routes dout1 back to its requester.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

// Per-requester return decode: raises this requester's rvalid when the retiring tag is its own.
module ram_port1_rr_lane #(
  parameter int ID = 0,
  parameter int TW = 2
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          ret_vld,
  input  logic [TW-1:0] ret_tag,
  output logic          rvalid
);
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) rvalid <= 1'b0;
    else        rvalid <= ret_vld && (ret_tag == TW'(ID));
endmodule

module ram_port1_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          cs1,
  output logic [ADDR_WIDTH-1:0]         addr1,
  input  logic [DATA_WIDTH-1:0]         dout1,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy
);
  localparam int TW = $clog2(NUM_REQ);

  logic [TW-1:0]              ptr, gnt_idx, nxt_ptr;
  logic                       xfer;
  logic [RD_LAT:0]            vld_pipe;
  logic [RD_LAT:0][TW-1:0]    tag_pipe;

  // Rotating priority scan starting at ptr; grant depends only on ptr, en and req.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !xfer && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = TW'(idx);
        xfer     = 1'b1;
      end
    end
  end

  assign nxt_ptr = (gnt_idx == TW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      cs1   <= 1'b0;
      addr1 <= '0;
      ptr   <= '0;
    end else begin
      cs1 <= xfer;
      if (xfer) begin
        addr1 <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ptr   <= nxt_ptr;
      end
    end

  // Stage k is live during cycle T+k of a read issued in cycle T; the last stage
  // coincides with dout1 being valid, so its edge captures the data.
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      rdata    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], xfer};
      tag_pipe <= {tag_pipe[RD_LAT-1:0], gnt_idx};
      if (vld_pipe[RD_LAT]) rdata <= dout1;
    end

  assign busy = |vld_pipe;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    ram_port1_rr_lane #(.ID(g), .TW(TW)) u_lane (
      .clk1    (clk1),
      .rst_n   (rst_n),
      .ret_vld (vld_pipe[RD_LAT]),
      .ret_tag (tag_pipe[RD_LAT]),
      .rvalid  (rvalid[g])
    );
  end
endmodule

// File: tb/tb_ram_port1_rr_arbiter.sv
// Directed bench: one arbiter at RD_LAT=1 with a scoreboard on returned reads,
// and one at RD_LAT=3 for dropping in-flight reads on reset.
module tb_ram_port1_rr_arbiter;
  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        en, en3;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [3:0]  gnt, rvalid, gnt3, rvalid3;
  logic        cs1, busy, cs1_3, busy3;
  logic [7:0]  addr1, dout1, rdata, addr1_3, dout3, rdata3;

  always #5 clk1 = ~clk1;

  ram_port1_rr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(1)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .en(en), .req(req), .req_addr(req_addr), .gnt(gnt),
    .cs1(cs1), .addr1(addr1), .dout1(dout1), .rvalid(rvalid), .rdata(rdata), .busy(busy));

  ram_port1_rr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(3)) u_dut3 (
    .clk1(clk1), .rst_n(rst_n), .en(en3), .req(req), .req_addr(req_addr), .gnt(gnt3),
    .cs1(cs1_3), .addr1(addr1_3), .dout1(dout3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3));

  // RAM models: read data appears RD_LAT cycles after the cs1 cycle.
  logic [7:0] mem [0:255];
  logic [7:0] d1q;
  logic [7:0] d3q [3];
  always @(posedge clk1) if (cs1) d1q <= mem[addr1];
  always @(posedge clk1) begin
    if (cs1_3) d3q[0] <= mem[addr1_3];
    d3q[1] <= d3q[0];
    d3q[2] <= d3q[1];
  end
  assign dout1 = d1q;
  assign dout3 = d3q[2];

  typedef struct packed { logic [3:0] rv; logic [7:0] d; } item_t;
  item_t      sb[$];
  int         n_chk = 0, n_pass = 0;
  logic [7:0] ra [4];
  logic [3:0] h [3];
  logic [7:0] exp_addr;
  logic       watch3 = 1'b0;
  int         bad3 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk1) begin
    item_t it;
    if (rst_n && rvalid != 4'b0) begin
      if (sb.size() == 0) chk("sb_unexpected", {28'b0, rvalid}, 32'h0);
      else begin
        it = sb.pop_front();
        chk("sb_rvalid", {28'b0, rvalid}, {28'b0, it.rv});
        chk("sb_rdata",  {24'b0, rdata},  {24'b0, it.d});
      end
    end
  end

  always @(negedge clk1) if (watch3 && rvalid3 != 4'b0) bad3 <= bad3 + 1;

  // One cycle: drive at posedge+1, check at negedge. h[] holds expected grants of the
  // previous three cycles, giving cs1/addr1 (1 back), busy (1-2 back) and rvalid (3 back).
  task automatic step(input logic [3:0] r, input logic e, input logic [3:0] eg);
    int gi;
    gi  = oh2i(eg);
    req = r;
    en  = e;
    @(negedge clk1);
    chk("gnt",    {28'b0, gnt},    {28'b0, eg});
    chk("cs1",    {31'b0, cs1},    {31'b0, h[0] != 4'b0});
    chk("addr1",  {24'b0, addr1},  {24'b0, exp_addr});
    chk("rvalid", {28'b0, rvalid}, {28'b0, h[2]});
    chk("busy",   {31'b0, busy},   {31'b0, (h[0] | h[1]) != 4'b0});
    if (eg != 4'b0) begin
      sb.push_back('{rv: eg, d: mem[ra[gi]]});
      exp_addr = ra[gi];
    end
    h[2] = h[1]; h[1] = h[0]; h[0] = eg;
    @(posedge clk1); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h15] = 8'hA7;
    ra[0] = 8'h10; ra[1] = 8'h2B; ra[2] = 8'h15; ra[3] = 8'h3C;
    req_addr = {ra[3], ra[2], ra[1], ra[0]};
    h[0] = '0; h[1] = '0; h[2] = '0;
    exp_addr = '0;
    rst_n = 1'b0; en = 1'b0; en3 = 1'b0; req = '0;
    #3;
    chk("rst_cs1",    {31'b0, cs1},    32'h0);
    chk("rst_addr1",  {24'b0, addr1},  32'h0);
    chk("rst_rvalid", {28'b0, rvalid}, 32'h0);
    chk("rst_rdata",  {24'b0, rdata},  32'h0);
    chk("rst_busy",   {31'b0, busy},   32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk1); #1;

    step(4'b0000, 1'b1, 4'b0000);
    // round robin with everyone requesting, including wrap 3 -> 0
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b1111, 1'b1, 4'b0010);
    step(4'b1111, 1'b1, 4'b0100);
    step(4'b1111, 1'b1, 4'b1000);
    step(4'b1111, 1'b1, 4'b0001);
    // idle keeps ptr at 1
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0011, 1'b1, 4'b0010);
    // single read of 0x15 from requester 2
    step(4'b0100, 1'b1, 4'b0100);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    // grant 3, then lone req[1]: ptr wraps to 0, scans to 1, ptr becomes 2
    step(4'b1000, 1'b1, 4'b1000);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b1111, 1'b1, 4'b0100);
    // en low for three cycles: in-flight read still returns, ptr held at 3
    step(4'b1111, 1'b0, 4'b0000);
    step(4'b1111, 1'b0, 4'b0000);
    step(4'b1111, 1'b0, 4'b0000);
    step(4'b1111, 1'b1, 4'b1000);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);

    // reset mid-flight on both arbiters
    en3 = 1'b1;
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b1111, 1'b1, 4'b0010);
    en3 = 1'b0;
    step(4'b1111, 1'b1, 4'b0100);
    req = 4'b0000;
    chk("pre_cs1",    {31'b0, cs1},    32'h1);
    chk("pre_rvalid", {28'b0, rvalid}, 32'h1);
    chk("pre_busy3",  {31'b0, busy3},  32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs1",    {31'b0, cs1},    32'h0);
    chk("arst_rvalid", {28'b0, rvalid}, 32'h0);
    chk("arst_busy",   {31'b0, busy},   32'h0);
    chk("arst_addr1",  {24'b0, addr1},  32'h0);
    chk("arst_busy3",  {31'b0, busy3},  32'h0);
    sb.delete();
    h[0] = '0; h[1] = '0; h[2] = '0;
    exp_addr = '0;
    @(negedge clk1);
    chk("arst_rdata", {24'b0, rdata}, 32'h0);
    #2 rst_n = 1'b1;
    watch3 = 1'b1;
    @(posedge clk1); #1;
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 4'b0000);
    watch3 = 1'b0;
    chk("rst3_no_rvalid", bad3, 0);
    chk("rst3_busy", {31'b0, busy3}, 32'h0);
    // ptr back at 0 in both: requesters 0 and 3 pending -> 0 wins
    req = 4'b1001; en = 1'b1; en3 = 1'b1;
    #1;
    chk("rst3_gnt", {28'b0, gnt3}, 32'h1);
    step(4'b1001, 1'b1, 4'b0001);
    en3 = 1'b0;
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 4'b0000);
    chk("rdata_hold", {24'b0, rdata},   {24'b0, mem[ra[0]]});
    chk("rvalid3",    {28'b0, rvalid3}, 32'h1);
    chk("rdata3",     {24'b0, rdata3},  {24'b0, mem[ra[0]]});
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_port1_rr_arbiter.md
Name: ram_port1_rr_arbiter

Overview:
- Round-robin arbiter that shares the single RAM read port 1 (cs1/addr1/dout1, clocked by clk1) among NUM_REQ read requesters.
- Accepts requests with a valid/ready handshake and drives cs1/addr1 from registers.
- Tracks outstanding reads through a tag pipeline matched to the RAM read latency, then returns dout1 to the originating requester.
- Sits between client blocks and the RAM's port-1 side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, `ADDR_WIDTH, RAM address width.
- DATA_WIDTH, `DATA_WIDTH, RAM data width.
- RD_LAT, 1, cycles from the cs1 cycle to dout1 valid (1..4).

Ports:
- clk1  in  1  port-1 clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable; 0 blocks new grants.
- req  in  NUM_REQ  per-requester read request (valid).
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; slice i belongs to requester i.
- gnt  out  NUM_REQ  combinational one-hot grant (ready).
- cs1  out  1  RAM port-1 chip select, registered.
- addr1  out  ADDR_WIDTH  RAM port-1 address, registered.
- dout1  in  DATA_WIDTH  RAM port-1 read data.
- rvalid  out  NUM_REQ  one-hot read-data-valid pulse, registered.
- rdata  out  DATA_WIDTH  returned data, registered; qualified by rvalid.
- busy  out  1  high while any read is outstanding in the tag pipeline.

Behaviour:
- Reset (async assert, sync deassert):
  - cs1=0, addr1=0, rvalid=0, rdata=0, busy=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - Tag pipeline cleared.
- Grant (combinational):
  - If en=0: gnt=0.
  - Otherwise gnt selects the first requester with req=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - gnt is at most one-hot and never depends on registered outputs of the same cycle.
- Transfer: occurs on an edge where req[i]&gnt[i]=1. At that edge:
  - cs1<=1 and addr1<=req_addr[i].
  - ptr<=(i+1) mod NUM_REQ.
  - Tag i enters pipeline stage 0.
- With no transfer at the edge: cs1<=0 and addr1 holds its value.
- Requester protocol:
  - Requester holds req and its address stable until it sees gnt.
  - Keeping req high after a transfer counts as a new request.
  - One transfer per cycle maximum; back-to-back issue every cycle is allowed.
- Read return:
  - A read issued with cs1=1 in cycle T has dout1 valid in cycle T+RD_LAT.
  - The arbiter samples dout1 at the end of cycle T+RD_LAT.
  - In cycle T+RD_LAT+1: rdata=dout1 and rvalid[tag]=1 for exactly one cycle.
  - Total latency from handshake edge to rvalid: RD_LAT+1 cycles.
  - When no read returns in a cycle: rvalid=0 and rdata holds.
- Tag pipeline: RD_LAT+1 stages, each holding {valid, tag}; busy = OR of all stage valid bits.
- Boundaries:
  - No requests: ptr unchanged, cs1=0.
  - ptr wraps from NUM_REQ-1 to 0.
  - en deasserted mid-stream: no new grants; already-issued reads still complete and return.
  - Same requester requesting continuously while others request: served at most once per NUM_REQ grants (starvation-free).
  - Reset mid-operation: outstanding reads are dropped and no rvalid is produced for them.

Test Plan:
- Reset: apply rst_n=0 mid-cycle -> cs1, rvalid and busy go to 0 immediately (async); after release with no req: cs1=0, gnt=0.
- Single read, RD_LAT=1: req[2]=1, addr=0x15, RAM[0x15]=0xA7 -> gnt=4'b0100; next cycle cs1=1, addr1=0x15; 2 cycles after handshake rvalid=4'b0100, rdata=0xA7.
- Round-robin fairness: all four req held high with en=1 -> grants 0,1,2,3,0 on consecutive cycles; cs1 stays high continuously; rvalid returns in order 0,1,2,3,0 with the matching data.
- Pointer wrap: grant to 3 while only req[1] is active -> next grant goes to 1; ptr becomes 2.
- Enable gating: en=0 for 3 cycles with requests pending -> gnt=0, cs1=0, and in-flight reads still return; en=1 -> arbitration resumes from the saved ptr.
- Reset mid-flight, RD_LAT=3: issue 2 reads, then assert rst_n=0 one cycle later -> no rvalid after release, busy=0, ptr=0.
